// File: rtl/z80_bus_master.sv
// z80_bus_master
// Purpose: Z80-style bus-cycle initiator for the Laser 310 64K expansion
// board. A valid/ready command stream is turned into memory and I/O read or
// write cycles. Each Z80 T-state lasts one clock cycle. The cycle sequence is
// IDLE -> T1 -> T2 -> (TW...) -> T3 -> T4 -> IDLE.
//
// Optional feature: define Z80BM_REFRESH_EN to add a two-state refresh tail
// (RF1, RF2) after every memory cycle. The tail drives a 7-bit R counter onto
// the address bus.
//
// Parameters:
//   WAIT_STATES  fixed extra TW states after T2 in every cycle (0..15)
// Ports:
//   i_clk, i_rst          clock, synchronous active-high reset
//   i_cmd_valid           command present
//   o_cmd_ready           high only in IDLE while not in reset
//   i_cmd_op              00 mem rd, 01 mem wr, 10 io rd, 11 io wr
//   i_cmd_addr            16-bit cycle address
//   i_cmd_wdata           8-bit write data
//   o_rsp_valid           one-cycle pulse in T4 of every cycle
//   o_rsp_rdata           read data captured at the T3->T4 edge
//   o_bus_addr            address bus
//   o_bus_dout, o_bus_doe write data and its drive enable
//   i_bus_din             read data from the bus
//   o_mreq_n, o_iorq_n    active-low address-space strobes
//   o_rd_n, o_wr_n        active-low direction strobes
//   i_wait_n              external wait request, active low
module z80_bus_master #(
  parameter int WAIT_STATES = 0
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_cmd_valid,
  output logic        o_cmd_ready,
  input  logic [1:0]  i_cmd_op,
  input  logic [15:0] i_cmd_addr,
  input  logic [7:0]  i_cmd_wdata,
  output logic        o_rsp_valid,
  output logic [7:0]  o_rsp_rdata,
  output logic [15:0] o_bus_addr,
  output logic [7:0]  o_bus_dout,
  output logic        o_bus_doe,
  input  logic [7:0]  i_bus_din,
  output logic        o_mreq_n,
  output logic        o_iorq_n,
  output logic        o_rd_n,
  output logic        o_wr_n,
  input  logic        i_wait_n
);

  localparam logic [3:0] C_WAIT = 4'(WAIT_STATES);

  typedef enum logic [2:0] {
    S_IDLE,
    S_T1,
    S_T2,
    S_TW,
    S_T3,
    S_T4
`ifdef Z80BM_REFRESH_EN
    , S_RF1,
    S_RF2
`endif
  } state_t;

  state_t      r_state;
  state_t      w_nextState;

  logic        r_isIo;
  logic        r_isWrite;
  logic        r_ioAutoWait;
  logic [3:0]  r_waitCnt;
  logic [15:0] r_busAddr;
  logic [7:0]  r_busDout;
  logic [7:0]  r_rspRdata;
`ifdef Z80BM_REFRESH_EN
  logic [6:0]  r_refresh;
`endif

  logic        r_mreqN;
  logic        r_iorqN;
  logic        r_rdN;
  logic        r_wrN;
  logic        r_doe;
  logic        r_rspValid;

  logic        w_cmdReady;
  logic        w_accept;
  logic        w_nIsIo;
  logic        w_nIsWrite;
  logic        w_mreqN;
  logic        w_iorqN;
  logic        w_rdN;
  logic        w_wrN;
  logic        w_doe;
  logic        w_rspValid;

  assign w_cmdReady = (r_state == S_IDLE) && !i_rst;
  assign w_accept   = i_cmd_valid && w_cmdReady;

  // The attributes of the cycle that will run after the next edge. They let
  // the strobes be registered straight from the next state.
  assign w_nIsIo    = w_accept ? i_cmd_op[1] : r_isIo;
  assign w_nIsWrite = w_accept ? i_cmd_op[0] : r_isWrite;

  // State register
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state logic. Leaving T2/TW follows a priority order: first the I/O
  // automatic wait, then the fixed wait count, and only after that WAIT_N.
  // As a result WAIT_N is never looked at during the fixed waits.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      S_IDLE: if (w_accept) w_nextState = S_T1;
      S_T1:   w_nextState = S_T2;
      S_T2, S_TW: begin
        if (r_ioAutoWait || (r_waitCnt != 4'd0) || !i_wait_n) begin
          w_nextState = S_TW;
        end else begin
          w_nextState = S_T3;
        end
      end
      S_T3:   w_nextState = S_T4;
`ifdef Z80BM_REFRESH_EN
      S_T4:   w_nextState = r_isIo ? S_IDLE : S_RF1;
      S_RF1:  w_nextState = S_RF2;
      S_RF2:  w_nextState = S_IDLE;
`else
      S_T4:   w_nextState = S_IDLE;
`endif
      default: w_nextState = S_IDLE;
    endcase
  end

  // Output decode of the upcoming state. It feeds the output registers, so
  // every strobe comes from a flop and only moves on the clock edge.
  always_comb begin
    w_mreqN    = 1'b1;
    w_iorqN    = 1'b1;
    w_rdN      = 1'b1;
    w_wrN      = 1'b1;
    w_doe      = 1'b0;
    w_rspValid = 1'b0;
    case (w_nextState)
      S_T1: w_doe = w_nIsWrite;
      S_T2, S_TW, S_T3: begin
        w_doe   = w_nIsWrite;
        w_mreqN = w_nIsIo;
        w_iorqN = !w_nIsIo;
        w_rdN   = w_nIsWrite;
        w_wrN   = !w_nIsWrite;
      end
      S_T4: begin
        w_doe      = w_nIsWrite;
        w_rspValid = 1'b1;
      end
`ifdef Z80BM_REFRESH_EN
      S_RF1: w_mreqN = 1'b0;
`endif
      default: ;
    endcase
  end

  // Output registers
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_mreqN    <= 1'b1;
      r_iorqN    <= 1'b1;
      r_rdN      <= 1'b1;
      r_wrN      <= 1'b1;
      r_doe      <= 1'b0;
      r_rspValid <= 1'b0;
    end else begin
      r_mreqN    <= w_mreqN;
      r_iorqN    <= w_iorqN;
      r_rdN      <= w_rdN;
      r_wrN      <= w_wrN;
      r_doe      <= w_doe;
      r_rspValid <= w_rspValid;
    end
  end

  // Datapath. It latches the command at accept, counts down the inserted
  // waits, captures the read data and, when enabled, steps the refresh
  // address.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_isIo       <= 1'b0;
      r_isWrite    <= 1'b0;
      r_ioAutoWait <= 1'b0;
      r_waitCnt    <= 4'd0;
      r_busAddr    <= 16'h0000;
      r_busDout    <= 8'h00;
      r_rspRdata   <= 8'h00;
`ifdef Z80BM_REFRESH_EN
      r_refresh    <= 7'd0;
`endif
    end else begin
      if (w_accept) begin
        r_isIo       <= i_cmd_op[1];
        r_isWrite    <= i_cmd_op[0];
        r_ioAutoWait <= i_cmd_op[1];
        r_waitCnt    <= C_WAIT;
        r_busAddr    <= i_cmd_addr;
        if (i_cmd_op[0]) begin
          r_busDout <= i_cmd_wdata;
        end
      end
      if ((r_state == S_T2) || (r_state == S_TW)) begin
        if (r_ioAutoWait) begin
          r_ioAutoWait <= 1'b0;
        end else if (r_waitCnt != 4'd0) begin
          r_waitCnt <= r_waitCnt - 4'd1;
        end
      end
      if ((r_state == S_T3) && !r_isWrite) begin
        r_rspRdata <= i_bus_din;
      end
`ifdef Z80BM_REFRESH_EN
      if ((r_state == S_T4) && !r_isIo) begin
        r_busAddr <= {9'b0, r_refresh};
      end
      if (r_state == S_RF2) begin
        r_refresh <= r_refresh + 7'd1;
      end
`endif
    end
  end

  assign o_cmd_ready = w_cmdReady;
  assign o_rsp_valid = r_rspValid;
  assign o_rsp_rdata = r_rspRdata;
  assign o_bus_addr  = r_busAddr;
  assign o_bus_dout  = r_busDout;
  assign o_bus_doe   = r_doe;
  assign o_mreq_n    = r_mreqN;
  assign o_iorq_n    = r_iorqN;
  assign o_rd_n      = r_rdN;
  assign o_wr_n      = r_wrN;

endmodule

// File: tb/tb_z80_bus_master.sv
// tb_z80_bus_master
// Directed bench for z80_bus_master. The main instance uses WAIT_STATES=0.
// A second instance with WAIT_STATES=2 covers the fixed-wait and back-to-back
// behaviour. Both instances share the command fields, the read data and
// WAIT_N, and each has its own cmd_valid.
module tb_z80_bus_master;

  typedef struct {
    logic [1:0]  op;
    logic [15:0] addr;
    logic [7:0]  wdata;
    logic [7:0]  din;
    int          waitLow;
    int          expLat;
    int          expWidth;
    logic [7:0]  expRdata;
  } vec_t;

  logic        clk;
  logic        rst;
  logic        cmdValid;
  logic        cmdValid2;
  logic [1:0]  cmdOp;
  logic [15:0] cmdAddr;
  logic [7:0]  cmdWdata;
  logic [7:0]  busDin;
  logic        waitN;

  logic        cmdReady,  cmdReady2;
  logic        rspValid,  rspValid2;
  logic [7:0]  rspRdata,  rspRdata2;
  logic [15:0] busAddr,   busAddr2;
  logic [7:0]  busDout,   busDout2;
  logic        busDoe,    busDoe2;
  logic        mreqN,     mreqN2;
  logic        iorqN,     iorqN2;
  logic        rdN,       rdN2;
  logic        wrN,       wrN2;

  int          checks;
  int          errors;
  logic [6:0]  expR;
  vec_t        vecs[6];

  z80_bus_master #(.WAIT_STATES(0)) dut (
    .i_clk(clk), .i_rst(rst), .i_cmd_valid(cmdValid), .o_cmd_ready(cmdReady),
    .i_cmd_op(cmdOp), .i_cmd_addr(cmdAddr), .i_cmd_wdata(cmdWdata),
    .o_rsp_valid(rspValid), .o_rsp_rdata(rspRdata), .o_bus_addr(busAddr),
    .o_bus_dout(busDout), .o_bus_doe(busDoe), .i_bus_din(busDin),
    .o_mreq_n(mreqN), .o_iorq_n(iorqN), .o_rd_n(rdN), .o_wr_n(wrN),
    .i_wait_n(waitN)
  );

  z80_bus_master #(.WAIT_STATES(2)) dut2 (
    .i_clk(clk), .i_rst(rst), .i_cmd_valid(cmdValid2), .o_cmd_ready(cmdReady2),
    .i_cmd_op(cmdOp), .i_cmd_addr(cmdAddr), .i_cmd_wdata(cmdWdata),
    .o_rsp_valid(rspValid2), .o_rsp_rdata(rspRdata2), .o_bus_addr(busAddr2),
    .o_bus_dout(busDout2), .o_bus_doe(busDoe2), .i_bus_din(busDin),
    .o_mreq_n(mreqN2), .o_iorq_n(iorqN2), .o_rd_n(rdN2), .o_wr_n(wrN2),
    .i_wait_n(waitN)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One comparison: count it, and report it when it does not match.
  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Runs one command on the main instance. It observes every cycle at the
  // negedge and then checks the accumulated timing and bus behaviour.
  task automatic applyStimulus(input vec_t v);
    int k;
    int rspAt;
    int dirLow;
    int spaceLow;
    int wrongSpace;
    int bothRw;
    int addrBad;
    int doeBad;
    int doutBad;
    int readyBad;
    logic [7:0] rdata;
    logic isIo;
    logic isWr;
    isIo = v.op[1];
    isWr = v.op[0];
    k = 0;
    while (cmdReady !== 1'b1 && k < 40) begin
      @(negedge clk);
      k++;
    end
    checkOutput("readyBeforeCmd", {31'b0, cmdReady}, 32'd1);
    cmdValid = 1'b1;
    cmdOp    = v.op;
    cmdAddr  = v.addr;
    cmdWdata = v.wdata;
    waitN    = 1'b1;
    busDin   = 8'hEE;
    rspAt = 0; dirLow = 0; spaceLow = 0; wrongSpace = 0; bothRw = 0;
    addrBad = 0; doeBad = 0; doutBad = 0; readyBad = 0; rdata = 8'h00;
    k = 0;
    while (rspAt == 0 && k < 40) begin
      @(negedge clk);
      k++;
      cmdValid = 1'b0;
      cmdOp    = 2'b00;
      cmdAddr  = 16'h0000;
      cmdWdata = 8'h00;
      if ((isWr ? wrN : rdN) == 1'b0) dirLow++;
      if ((isIo ? iorqN : mreqN) == 1'b0) spaceLow++;
      if ((isIo ? mreqN : iorqN) == 1'b0) wrongSpace++;
      if (!rdN && !wrN) bothRw++;
      if (busAddr !== v.addr) addrBad++;
      if (busDoe !== isWr) doeBad++;
      if (isWr && busDout !== v.wdata) doutBad++;
      if (cmdReady !== 1'b0) readyBad++;
      if (rspValid === 1'b1) begin
        rspAt = k;
        rdata = rspRdata;
      end
      waitN  = !(k >= 2 && k < 2 + v.waitLow);
      busDin = (k == v.expLat - 1) ? v.din : 8'hEE;
    end
    checkOutput("latency", rspAt, v.expLat);
    checkOutput("dirStrobeWidth", dirLow, v.expWidth);
    checkOutput("spaceStrobeWidth", spaceLow, v.expWidth);
    checkOutput("wrongSpaceStrobe", wrongSpace, 0);
    checkOutput("rdWrOverlap", bothRw, 0);
    checkOutput("addrUnstable", addrBad, 0);
    checkOutput("doeWrong", doeBad, 0);
    checkOutput("doutUnstable", doutBad, 0);
    checkOutput("readyDuringCycle", readyBad, 0);
    checkOutput("rspRdata", {24'b0, rdata}, {24'b0, v.expRdata});
    @(negedge clk);
    waitN  = 1'b1;
    busDin = 8'hEE;
`ifdef Z80BM_REFRESH_EN
    if (!isIo) begin
      checkOutput("rf1Mreq", {31'b0, mreqN}, 32'd0);
      checkOutput("rf1RdWrIorq", {29'b0, rdN, wrN, iorqN}, 32'd7);
      checkOutput("rf1Addr", {16'b0, busAddr}, {25'b0, expR});
      checkOutput("rf1Doe", {31'b0, busDoe}, 32'd0);
      checkOutput("rf1Ready", {31'b0, cmdReady}, 32'd0);
      @(negedge clk);
      checkOutput("rf2Mreq", {31'b0, mreqN}, 32'd1);
      checkOutput("rf2Ready", {31'b0, cmdReady}, 32'd0);
      @(negedge clk);
      checkOutput("afterRefreshReady", {31'b0, cmdReady}, 32'd1);
      expR = expR + 7'd1;
    end else begin
`endif
      checkOutput("idleReady", {31'b0, cmdReady}, 32'd1);
      checkOutput("idleStrobes", {28'b0, mreqN, iorqN, rdN, wrN}, 32'hF);
      checkOutput("idleDoe", {31'b0, busDoe}, 32'd0);
      checkOutput("idleRspValid", {31'b0, rspValid}, 32'd0);
      checkOutput("idleAddrHeld", {16'b0, busAddr}, {16'b0, v.addr});
`ifdef Z80BM_REFRESH_EN
    end
`endif
  endtask

`ifdef Z80BM_REFRESH_EN
  localparam int EXP_B2B = 9;
`else
  localparam int EXP_B2B = 7;
`endif

  initial begin
    vec_t x;
    int k;
    int rspCount;
    int firstRsp;
    int secondRsp;
    int acceptK;
    int rdLow2;
    int wrLow2;
    int readyBad2;
    logic [7:0] rdata2;

    checks = 0;
    errors = 0;
    expR   = 7'd0;

    //           op     addr      wdata  din    wl lat w  rdata
    vecs[0] = '{2'b11, 16'h0070, 8'h02, 8'h00, 0, 5, 3, 8'h00};
    vecs[1] = '{2'b00, 16'hB800, 8'h00, 8'hA5, 0, 4, 2, 8'hA5};
    vecs[2] = '{2'b01, 16'hC000, 8'h5A, 8'h00, 3, 7, 5, 8'hA5};
    vecs[3] = '{2'b10, 16'h0075, 8'h00, 8'h3C, 0, 5, 3, 8'h3C};
    vecs[4] = '{2'b01, 16'h1234, 8'hFF, 8'h00, 0, 4, 2, 8'h3C};
    vecs[5] = '{2'b00, 16'h0000, 8'h00, 8'h81, 1, 5, 3, 8'h81};

    rst = 1'b1; cmdValid = 1'b0; cmdValid2 = 1'b0; cmdOp = 2'b00;
    cmdAddr = 16'h0000; cmdWdata = 8'h00; busDin = 8'hEE; waitN = 1'b1;

    // Reset values
    @(negedge clk);
    @(negedge clk);
    checkOutput("rstReady", {31'b0, cmdReady}, 32'd0);
    checkOutput("rstStrobes", {28'b0, mreqN, iorqN, rdN, wrN}, 32'hF);
    checkOutput("rstAddr", {16'b0, busAddr}, 32'd0);
    checkOutput("rstDout", {24'b0, busDout}, 32'd0);
    checkOutput("rstDoe", {31'b0, busDoe}, 32'd0);
    checkOutput("rstRsp", {23'b0, rspValid, rspRdata}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("readyAfterRst", {31'b0, cmdReady}, 32'd1);

    for (int i = 0; i < 6; i++) begin
      applyStimulus(vecs[i]);
    end

    // Reset pulsed during T2 of a memory write
    cmdValid = 1'b1; cmdOp = 2'b01; cmdAddr = 16'h2222; cmdWdata = 8'h99;
    @(negedge clk);
    cmdValid = 1'b0;
    @(negedge clk);
    checkOutput("midT2WrLow", {31'b0, wrN}, 32'd0);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("abortStrobes", {28'b0, mreqN, iorqN, rdN, wrN}, 32'hF);
    checkOutput("abortDoe", {31'b0, busDoe}, 32'd0);
    checkOutput("abortAddr", {16'b0, busAddr}, 32'd0);
    checkOutput("abortDout", {24'b0, busDout}, 32'd0);
    checkOutput("abortReadyInRst", {31'b0, cmdReady}, 32'd0);
    rst = 1'b0;
    expR = 7'd0;
    rspCount = 0;
    @(negedge clk);
    checkOutput("abortReadyAfter", {31'b0, cmdReady}, 32'd1);
    for (int i = 0; i < 6; i++) begin
      if (rspValid === 1'b1) rspCount++;
      @(negedge clk);
    end
    checkOutput("abortNoRsp", rspCount, 0);

    // Two memory reads and an I/O read after the reset
    x = '{2'b00, 16'h0100, 8'h00, 8'h11, 0, 4, 2, 8'h11};
    applyStimulus(x);
    x = '{2'b00, 16'h0101, 8'h00, 8'h22, 0, 4, 2, 8'h22};
    applyStimulus(x);
    x = '{2'b10, 16'h007F, 8'h00, 8'h44, 0, 5, 3, 8'h44};
    applyStimulus(x);

    // WAIT_STATES=2: memory read of 0xFFFF, then a write held back-to-back
    cmdValid2 = 1'b1; cmdOp = 2'b00; cmdAddr = 16'hFFFF; cmdWdata = 8'h00;
    firstRsp = 0; secondRsp = 0; acceptK = 0; rdLow2 = 0; wrLow2 = 0;
    readyBad2 = 0; rdata2 = 8'h00;
    for (k = 1; k <= 30; k++) begin
      @(negedge clk);
      if (k == 1) begin
        cmdOp = 2'b01; cmdAddr = 16'h4000; cmdWdata = 8'h77;
      end
      if (acceptK != 0 && k > acceptK) cmdValid2 = 1'b0;
      if (!rdN2) rdLow2++;
      if (!wrN2) wrLow2++;
      if (rspValid2 === 1'b1) begin
        if (firstRsp == 0) begin
          firstRsp = k;
          rdata2 = rspRdata2;
        end else if (secondRsp == 0) begin
          secondRsp = k;
        end
      end
      if (firstRsp == 0 && cmdReady2 !== 1'b0) readyBad2++;
      if (acceptK == 0 && firstRsp != 0 && cmdReady2 === 1'b1 && cmdValid2) acceptK = k;
      busDin = (k == 5) ? 8'hC3 : 8'hEE;
    end
    checkOutput("ws2Latency", firstRsp, 6);
    checkOutput("ws2RdWidth", rdLow2, 4);
    checkOutput("ws2Rdata", {24'b0, rdata2}, 32'hC3);
    checkOutput("ws2ReadyLow", readyBad2, 0);
    checkOutput("ws2SecondAccept", acceptK, EXP_B2B);
    checkOutput("ws2SecondLatency", secondRsp - acceptK, 6);
    checkOutput("ws2WrWidth", wrLow2, 4);
    checkOutput("ws2SecondAddr", {16'b0, busAddr2}, 32'h4000);
    checkOutput("ws2SecondDout", {24'b0, busDout2}, 32'h77);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/z80_bus_master.md
# z80_bus_master

Synchronous Z80 bus-cycle initiator for the Laser 310 64K expansion board. It turns a simple valid/ready command stream into Z80-style memory and I/O read/write cycles on MREQ_N/IORQ_N/RD_N/WR_N, address and data. It exercises the board's RAM decoder and bank-select port (I/O 0x70–0x7F, D1..D0) from an on-board or bring-up controller in place of the CPU. Each Z80 T-state is modelled as one `clk` cycle.

## Interface
- WAIT_STATES, 0: fixed extra TW states inserted after T2 in every cycle (0–15).
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  high only in IDLE and not in reset; a transfer occurs on `cmd_valid && cmd_ready`.
- cmd_op  in  2  00 mem read, 01 mem write, 10 I/O read, 11 I/O write.
- cmd_addr  in  16  cycle address.
- cmd_wdata  in  8  write data.
- rsp_valid  out  1  one-cycle pulse at end of every cycle (reads and writes).
- rsp_rdata  out  8  captured read data; holds its value until the next read.
- bus_addr  out  16  address bus.
- bus_dout  out  8  write data.
- bus_doe  out  1  data-bus drive enable.
- bus_din  in  8  read data from the bus.
- MREQ_N, IORQ_N, RD_N, WR_N  out  1 each  active-low strobes.
- WAIT_N  in  1  external wait request, active low.

## Operation
- States: IDLE, T1, T2, TW, T3, T4, plus RF1/RF2 when `Z80BM_REFRESH_EN` is defined.
- Accept: command fields are latched. IDLE → T1.
- T1:
  - `bus_addr` = latched address.
  - Strobes inactive.
  - For writes, `bus_dout` = wdata and `bus_doe` = 1.
- T2:
  - MREQ_N (mem) or IORQ_N (I/O) goes low.
  - RD_N goes low for reads; WR_N goes low for writes.
- TW sequence after T2:
  - I/O cycles first get one automatic TW.
  - Then WAIT_STATES fixed TWs, counted by a 4-bit counter.
  - Then WAIT_N is sampled at the end of T2 and of each TW. While it is low, another TW follows.
- T3:
  - Strobes stay asserted.
  - For reads, `bus_din` is registered into `rsp_rdata` at the T3→T4 edge.
- T4:
  - All strobes high.
  - `bus_addr`, `bus_dout` and `bus_doe` are held.
  - `rsp_valid` = 1.
  - T4 → IDLE.
- IDLE: `bus_doe` = 0; `bus_addr` and `bus_dout` keep their last values.
- Strobe invariants:
  - Never both MREQ_N and IORQ_N low.
  - Never both RD_N and WR_N low.
  - All strobes change only on posedge `clk`.
- I/O address: the full 16-bit cmd_addr is driven; the decoder uses A7..A4.

## Timing
- Reset values:
  - MREQ_N, IORQ_N, RD_N, WR_N = 1.
  - bus_addr = 0, bus_dout = 0, bus_doe = 0.
  - rsp_valid = 0, rsp_rdata = 0.
  - cmd_ready = 0 during rst, 1 in the first cycle after rst deasserts.
  - State = IDLE; refresh counter = 0.
- Latency from the accept edge to the `rsp_valid` cycle:
  - mem: 4 + WAIT_STATES + N_wait cycles.
  - I/O: 5 + WAIT_STATES + N_wait cycles.
- Strobe-low width:
  - mem: 2 + WAIT_STATES + N_wait cycles.
  - I/O: 3 + WAIT_STATES + N_wait cycles.
  - Minimum 2, so at least one posedge falls with strobes and data stable, as needed for the synchronous bank latch.
- Throughput: cmd_ready is low from T1 through T4. Minimum issue interval is 5 cycles for mem, 6 for I/O (longer with refresh).
- WAIT_N is ignored outside T2/TW, and is not sampled during fixed wait states.
- Reset mid-cycle (any state): the next edge forces all outputs to their reset values. No rsp_valid is produced for the aborted cycle.
- `cmd_valid` while not ready has no effect. Command inputs are sampled only at the accept edge.

## Configuration
- `Z80BM_REFRESH_EN` defined:
  - After every memory cycle's T4, insert RF1 then RF2 before IDLE.
  - `bus_addr` = {9'b0, R[6:0]}.
  - MREQ_N is low in RF1 only; RD_N, WR_N and IORQ_N stay high; `bus_doe` = 0.
  - R increments (mod 128) at the RF2→IDLE edge.
  - `rsp_valid` is still issued in T4. cmd_ready stays low until IDLE.
  - I/O cycles never refresh.
- Not defined: no RF states and no R counter; T4 → IDLE directly.

## Test plan
- Reset, then I/O write op=11 addr=0x0070 wdata=0x02:
  - IORQ_N and WR_N low for exactly 3 cycles.
  - bus_addr=0x0070 and bus_doe=1 from T1 to T4.
  - rsp_valid 5 cycles after accept; MREQ_N stays 1 throughout.
- Mem read op=00 addr=0xB800, bus_din=0xA5 during T3:
  - MREQ_N and RD_N low for 2 cycles.
  - rsp_valid 4 cycles after accept with rsp_rdata=0xA5.
- Mem write 0xC000 ← 0x5A with WAIT_N held low for 3 cycles starting in T2:
  - WR_N low width = 5 cycles.
  - bus_dout=0x5A stable throughout; rsp_valid at cycle 7.
- WAIT_STATES=2, mem read 0xFFFF, WAIT_N=1:
  - Strobe width 4; rsp_valid at cycle 6.
  - Back-to-back cmd_valid accepted only after returning to IDLE.
- rst pulsed for one cycle during T2 of a mem write:
  - All strobes high and bus_doe=0 on the next edge; no rsp_valid.
  - cmd_ready=1 one cycle after rst drops.
- With `Z80BM_REFRESH_EN`: two mem reads:
  - Each is followed by a 1-cycle MREQ_N-low pulse with RD_N=WR_N=1.
  - Refresh addresses are 0x0000 then 0x0001.
  - An I/O read issues no refresh.
